// File: rtl/nspi_pkg.sv
// Shared types and helpers for the nspi frame sequencer.
package nspi_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR, FETCH, LOAD, START, ACK, DONE, BGAP, FGAP
  } seq_state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Width needed to hold a gap count of n (at least one bit).
  function automatic int gap_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nspi_gap_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module nspi_gap_timer
  import nspi_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/nspi_frame_sequencer.sv
// Streams one frame-buffer frame through the multi-lane SPI transmitter, one byte per lane per transfer.
// Define NSPI_FRAME_HEADER_EN to prefix every frame with a HEADER_BYTE transfer on all lanes.
module nspi_frame_sequencer
  import nspi_pkg::*;
#(
  parameter int CHANNEL_NUMBER  = 3,
  parameter int SPI_SIZE        = 8,
  parameter int BYTES_PER_FRAME = 384,
  parameter int BYTE_GAP        = 2,
  parameter int FRAME_GAP       = 64,
  parameter int ADDR_W          = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               rd_en,
  output logic [ADDR_W-1:0]                  rd_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] tx_data,
  output logic                               tx_start,
  input  logic                               tx_finish
);

  localparam int GAP_MAX = (FRAME_GAP > BYTE_GAP) ? FRAME_GAP : BYTE_GAP;
  localparam int GAP_W   = gap_cnt_width(GAP_MAX);
  // FGAP spans FRAME_GAP idle cycles plus the frame_done cycle; BGAP spans exactly BYTE_GAP.
  localparam logic [GAP_W-1:0]    FGAP_LOAD = GAP_W'(FRAME_GAP);
  localparam logic [GAP_W-1:0]    BGAP_LOAD = GAP_W'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [SPI_SIZE-1:0] HDR_WORD  = SPI_SIZE'(HEADER_BYTE);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              pending, hdr_phase;
  logic              new_frame, ld_tx, ld_hdr, inc_idx, gap_load, gap_done;
  logic [GAP_W-1:0]  gap_val;
  logic              last_idx;

  assign rd_addr  = idx;
  assign last_idx = (idx == ADDR_W'(BYTES_PER_FRAME - 1));

  nspi_gap_timer #(.CNT_W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_val),
    .done     (gap_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    rd_en      = 1'b0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    new_frame  = 1'b0;
    ld_tx      = 1'b0;
    ld_hdr     = 1'b0;
    inc_idx    = 1'b0;
    gap_load   = 1'b0;
    gap_val    = BGAP_LOAD;
    case (state)
      IDLE: begin
        if (frame_start) begin
          new_frame = 1'b1;
`ifdef NSPI_FRAME_HEADER_EN
          state_nxt = HDR;
`else
          state_nxt = FETCH;
`endif
        end
      end
`ifdef NSPI_FRAME_HEADER_EN
      HDR: begin
        ld_hdr    = 1'b1;
        state_nxt = START;
      end
`endif
      FETCH: begin
        rd_en     = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        ld_tx     = 1'b1;
        state_nxt = START;
      end
      START: begin
        tx_start  = 1'b1;
        state_nxt = ACK;
      end
      // Keep start asserted until the transmitter visibly accepts the transfer.
      ACK: begin
        tx_start = 1'b1;
        if (!tx_finish)
          state_nxt = DONE;
      end
      DONE: begin
        if (tx_finish) begin
          gap_load = 1'b1;
          if (!hdr_phase && last_idx) begin
            gap_val   = FGAP_LOAD;
            state_nxt = FGAP;
          end else begin
            inc_idx = !hdr_phase;
            if (BYTE_GAP > 0)
              state_nxt = BGAP;
            else
              state_nxt = FETCH;
          end
        end
      end
      BGAP: begin
        if (gap_done)
          state_nxt = FETCH;
      end
      FGAP: begin
        if (gap_done) begin
          frame_done = 1'b1;
          if (pending || frame_start) begin
            new_frame = 1'b1;
`ifdef NSPI_FRAME_HEADER_EN
            state_nxt = HDR;
`else
            state_nxt = FETCH;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      pending   <= 1'b0;
      hdr_phase <= 1'b0;
      tx_data   <= '0;
    end else begin
      if (new_frame)
        idx <= '0;
      else if (inc_idx)
        idx <= idx + ADDR_W'(1);
      // One-deep request queue; a request in the frame_done cycle stays queued if one was already waiting.
      if (state == IDLE)
        pending <= 1'b0;
      else if (frame_done)
        pending <= pending & frame_start;
      else if (frame_start)
        pending <= 1'b1;
      if (ld_hdr)
        hdr_phase <= 1'b1;
      else if (gap_load)
        hdr_phase <= 1'b0;
      if (ld_tx)
        tx_data <= rd_data;
      else if (ld_hdr)
        tx_data <= {CHANNEL_NUMBER{HDR_WORD}};
    end
  end

endmodule

// File: tb/tb_nspi_frame_sequencer.sv
// Self-checking bench for nspi_frame_sequencer with a transmitter model and a frame-buffer model.
module tb_nspi_frame_sequencer;

  localparam int CH  = 3;
  localparam int SW  = 8;
  localparam int BPF = 4;
  localparam int BG  = 2;
  localparam int FG  = 16;
  localparam int AW  = 2;
`ifdef NSPI_FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int PER       = BPF + HDR;
  localparam int FIRST_LAT = (HDR != 0) ? 2 : 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic busy, frame_done, rd_en, tx_start;
  logic tx_finish;
  logic [AW-1:0]    rd_addr;
  logic [CH*SW-1:0] rd_data = '0;
  logic [CH*SW-1:0] tx_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] salt = 8'h00;
  int tx_lo = 10;
  int tx_hi = 10;
  int tx_cnt;

  always #5 clk = ~clk;

  nspi_frame_sequencer #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SW), .BYTES_PER_FRAME(BPF),
    .BYTE_GAP(BG), .FRAME_GAP(FG)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx_data(tx_data), .tx_start(tx_start),
    .tx_finish(tx_finish)
  );

  function automatic logic [CH*SW-1:0] fb_word(input int addr, input logic [7:0] s);
    logic [CH*SW-1:0] w;
    w = '0;
    for (int c = 0; c < CH; c++) w[c*SW +: SW] = SW'(8'h11 * c + addr + int'(s));
    return w;
  endfunction

  // Expected lane data for the j-th transfer of a frame.
  function automatic logic [CH*SW-1:0] exp_xfer(input int j);
    if (HDR != 0 && j == 0) return {CH{8'hA5}};
    return fb_word(j - HDR, salt);
  endfunction

  // Transmitter: accepts start while idle, holds finish low for a random number of cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_finish <= 1'b1;
      tx_cnt    <= 0;
    end else if (tx_finish && tx_start) begin
      tx_finish <= 1'b0;
      tx_cnt    <= int'($urandom_range(tx_hi, tx_lo)) - 1;
    end else if (!tx_finish) begin
      if (tx_cnt == 0) tx_finish <= 1'b1;
      else tx_cnt <= tx_cnt - 1;
    end
  end

  // Frame buffer: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= fb_word(int'(rd_addr), salt);

  // Event recorder.
  int cyc = 0;
  logic ts_prev = 1'b0, tf_prev = 1'b1;
  int ts_t[$], tf_t[$], fd_t[$], rd_q[$];
  logic [CH*SW-1:0] tx_q[$];
  logic [CH*SW-1:0] snap = '0;
  bit inflight = 1'b0;
  int stab_err = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_start && !ts_prev) begin
        ts_t.push_back(cyc); tx_q.push_back(tx_data); snap = tx_data; inflight = 1'b1;
      end else if (inflight && tx_data !== snap) stab_err++;
      if (tx_finish && !tf_prev) begin tf_t.push_back(cyc); inflight = 1'b0; end
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (frame_done) fd_t.push_back(cyc);
    end else inflight = 1'b0;
    ts_prev = tx_start;
    tf_prev = tx_finish;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_q(input int which, input int n, output bit ok);
    int k = 0;
    while (((which == 0) ? ts_t.size() : fd_t.size()) < n && k < 5000) begin tick(1); k++; end
    ok = (((which == 0) ? ts_t.size() : fd_t.size()) >= n);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({busy, frame_done, rd_en, tx_start} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {busy, frame_done, rd_en, tx_start});
    end
    checks++;
    if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr got %0h exp 0", rd_addr); end
    checks++;
    if (tx_data !== '0) begin errors++; $display("FAIL reset_txdata got %h exp 0", tx_data); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_frame();
    int bts, btf, bfd, brd, bst, t0, got, bad;
    bit ok;
    salt = 8'($urandom); tx_lo = 10; tx_hi = 10;
    bts = ts_t.size(); btf = tf_t.size(); bfd = fd_t.size(); brd = rd_q.size(); bst = stab_err;
    frame_start = 1'b1; t0 = cyc; tick(1); frame_start = 1'b0;
    wait_q(1, bfd + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got %0d frames exp 1", fd_t.size() - bfd); end
    tick(FG + 40);
    got = (ts_t.size() > bts) ? ts_t[bts] - t0 : -1;
    checks++;
    if (got != FIRST_LAT) begin errors++; $display("FAIL single_latency got %0d exp %0d", got, FIRST_LAT); end
    checks++;
    if (ts_t.size() - bts != PER) begin
      errors++; $display("FAIL single_xfers got %0d exp %0d", ts_t.size() - bts, PER);
    end
    bad = 0;
    for (int j = 0; j < BPF; j++) if (rd_q.size() <= brd + j || rd_q[brd + j] != j) bad++;
    checks++;
    if (bad != 0 || rd_q.size() - brd != BPF) begin
      errors++; $display("FAIL single_rdaddr got %0d reads %0d bad exp %0d reads 0 bad", rd_q.size() - brd, bad, BPF);
    end
    bad = 0;
    for (int j = 0; j < PER; j++) if (tx_q.size() <= bts + j || tx_q[bts + j] !== exp_xfer(j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_txdata got %0d bad transfers exp 0", bad); end
    bad = 0;
    for (int j = 0; j < PER - 1; j++)
      if (ts_t.size() <= bts + j + 1 || tf_t.size() <= btf + j || ts_t[bts + j + 1] - tf_t[btf + j] != BG + 3) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_bytegap got %0d bad gaps exp 0", bad); end
    got = (fd_t.size() > bfd && tf_t.size() >= btf + PER) ? fd_t[bfd] - tf_t[btf + PER - 1] : -1;
    checks++;
    if (got != FG + 1) begin errors++; $display("FAIL single_framegap got %0d exp %0d", got, FG + 1); end
    checks++;
    if (fd_t.size() - bfd != 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", fd_t.size() - bfd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    checks++;
    if (stab_err != bst) begin errors++; $display("FAIL single_stable got %0d changes exp 0", stab_err - bst); end
  endtask

  task automatic test_back_to_back();
    int bts, btf, bfd, brd, bad;
    bit ok;
    salt = 8'($urandom); tx_lo = 2; tx_hi = 12;
    bts = ts_t.size(); btf = tf_t.size(); bfd = fd_t.size(); brd = rd_q.size();
    frame_start = 1'b1;
    wait_q(0, bts + PER + 2, ok);
    frame_start = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_hold_timeout got %0d xfers exp %0d", ts_t.size() - bts, PER + 2); end
    wait_q(1, bfd + 3, ok);
    tick(FG + 100);
    checks++;
    if (fd_t.size() - bfd != 3) begin errors++; $display("FAIL b2b_frames got %0d exp 3", fd_t.size() - bfd); end
    checks++;
    if (ts_t.size() - bts != 3 * PER) begin
      errors++; $display("FAIL b2b_xfers got %0d exp %0d", ts_t.size() - bts, 3 * PER);
    end
    bad = 0;
    for (int j = 0; j < 3 * BPF; j++) if (rd_q.size() <= brd + j || rd_q[brd + j] != j % BPF) bad++;
    for (int j = 0; j < 3 * PER; j++) if (tx_q.size() <= bts + j || tx_q[bts + j] !== exp_xfer(j % PER)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_data got %0d bad entries exp 0", bad); end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (fd_t.size() <= bfd + k || tf_t.size() < btf + (k + 1) * PER ||
          fd_t[bfd + k] - tf_t[btf + k * PER + PER - 1] != FG + 1) bad++;
      if (k < 2 && (fd_t.size() <= bfd + k || ts_t.size() <= bts + (k + 1) * PER ||
          ts_t[bts + (k + 1) * PER] - fd_t[bfd + k] != FIRST_LAT)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_spacing got %0d bad boundaries exp 0", bad); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_pending();
    int bts, bfd, bad;
    bit ok;
    salt = 8'($urandom); tx_lo = 2; tx_hi = 12;
    bts = ts_t.size(); bfd = fd_t.size();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_q(0, bts + 1, ok);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_q(0, bts + 3, ok);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_q(1, bfd + 2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pend_timeout got %0d frames exp 2", fd_t.size() - bfd); end
    tick(FG + 100);
    checks++;
    if (fd_t.size() - bfd != 2) begin errors++; $display("FAIL pend_frames got %0d exp 2", fd_t.size() - bfd); end
    bad = 0;
    for (int j = 0; j < 2 * PER; j++) if (tx_q.size() <= bts + j || tx_q[bts + j] !== exp_xfer(j % PER)) bad++;
    checks++;
    if (bad != 0 || ts_t.size() - bts != 2 * PER) begin
      errors++; $display("FAIL pend_xfers got %0d xfers %0d bad exp %0d xfers 0 bad", ts_t.size() - bts, bad, 2 * PER);
    end
  endtask

  task automatic test_reset_mid();
    int bts, brd, bfd, bad;
    bit ok;
    salt = 8'($urandom); tx_lo = 3; tx_hi = 8;
    bts = ts_t.size();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_q(0, bts + 1, ok);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_q(0, bts + HDR + 3, ok);
    tick(1);
    checks++;
    if (!ok || tx_start !== 1'b1 || tx_finish !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_ack got start=%b finish=%b exp start=1 finish=0", tx_start, tx_finish);
    end
    rst = 1'b1; #1;
    checks++;
    if ({busy, frame_done, rd_en, tx_start} !== 4'b0 || rd_addr !== '0 || tx_data !== '0) begin
      errors++; $display("FAIL rstmid_outputs got ctrl=%b addr=%0h data=%h exp all 0",
                         {busy, frame_done, rd_en, tx_start}, rd_addr, tx_data);
    end
    tick(2); rst = 1'b0;
    bts = ts_t.size(); brd = rd_q.size();
    tick(60);
    checks++;
    if (ts_t.size() != bts || rd_q.size() != brd || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_pending_dropped got %0d xfers %0d reads busy=%b exp 0 0 0",
                         ts_t.size() - bts, rd_q.size() - brd, busy);
    end
    salt = 8'($urandom); bfd = fd_t.size();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    wait_q(1, bfd + 1, ok);
    tick(10);
    bad = 0;
    for (int j = 0; j < BPF; j++) if (rd_q.size() <= brd + j || rd_q[brd + j] != j) bad++;
    for (int j = 0; j < PER; j++) if (tx_q.size() <= bts + j || tx_q[bts + j] !== exp_xfer(j)) bad++;
    checks++;
    if (!ok || bad != 0 || ts_t.size() - bts != PER) begin
      errors++; $display("FAIL rstmid_restart got %0d xfers %0d bad exp %0d xfers 0 bad", ts_t.size() - bts, bad, PER);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_pending();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nspi_frame_sequencer.md
Name: nspi_frame_sequencer

Overview:
- Sequences one full LED-matrix frame through the multi-channel SPI transmitter, one byte per channel per transfer.
- Reads per-channel bytes from the frame buffer, presents them on the transmitter's parallel data input and pulses its start input.
- Waits for the transmitter's finish flag, enforces inter-byte and end-of-frame gaps, then signals frame completion.
- Sits between the HDMI frame-buffer read side and the SPI transmitter.

Parameters:
- CHANNEL_NUMBER, 3, number of parallel SPI lanes (one matrix per lane).
- SPI_SIZE, 8, bits per transfer; must match the transmitter.
- BYTES_PER_FRAME, 384, transfers per frame (16x8 pixels x 3 colours).
- BYTE_GAP, 2, idle clk cycles between tx_finish rising and the next fetch.
- FRAME_GAP, 64, idle clk cycles after the last byte before frame_done; the matrices use this as frame sync.
- ADDR_W, $clog2(BYTES_PER_FRAME), frame-buffer address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  request to send one frame; level-sampled at posedge clk.
- busy  out  1  high from the accepted request until frame_done.
- frame_done  out  1  one-cycle pulse when a frame ends.
- rd_en  out  1  frame-buffer read strobe.
- rd_addr  out  ADDR_W  byte index within the frame.
- rd_data  in  [SPI_SIZE-1:0] x CHANNEL_NUMBER  per-channel byte, valid exactly 1 cycle after rd_en.
- tx_data  out  [SPI_SIZE-1:0] x CHANNEL_NUMBER  drives the transmitter data_in.
- tx_start  out  1  drives the transmitter start input.
- tx_finish  in  1  transmitter flag; low while a transfer is in progress.

Behaviour:
- Reset (async): state IDLE, busy=0, frame_done=0, rd_en=0, rd_addr=0, tx_start=0, tx_data all zero, pending=0, counters 0.
- FSM states:
  - IDLE -> FETCH when frame_start=1; sets busy=1 and clears the byte index.
  - FETCH: rd_en=1 for one cycle with rd_addr=index -> LOAD.
  - LOAD: register rd_data into tx_data -> START. tx_data then stays stable until the next LOAD.
  - START: tx_start=1 -> ACK.
  - ACK: hold tx_start=1 until tx_finish=0 is sampled, then drop tx_start -> DONE.
  - DONE: wait until tx_finish=1.
    - If index == BYTES_PER_FRAME-1 -> FGAP.
    - Otherwise index+1 -> BGAP.
  - BGAP: count BYTE_GAP cycles -> FETCH. BYTE_GAP=0 goes directly to FETCH.
  - FGAP: count FRAME_GAP cycles, then frame_done=1 for 1 cycle.
    - Goes to FETCH (busy stays 1) if pending=1, clearing pending.
    - Otherwise goes to IDLE with busy=0.
- Latency: frame_start to first tx_start rising edge = 3 clk (FETCH, LOAD, START).
- Index wrap: index never exceeds BYTES_PER_FRAME-1 and resets to 0 at each new frame.
- frame_start while busy: sets pending (1 deep). Further requests while pending=1 are dropped.
- frame_start in the same cycle frame_done fires: counts as pending, so back-to-back frames run with no extra IDLE cycle.
- tx_start rising edge occurs only in START. It is never re-asserted until tx_finish has gone low and back high.
- Reset mid-frame: immediate return to IDLE and a pending request is discarded. The transmitter is reset by the same rst.

Optional Feature:
- Macro: NSPI_FRAME_HEADER_EN.
- Defined: before byte 0 of each frame, an extra transfer sends the constant HEADER_BYTE (8'hA5, zero-extended to SPI_SIZE) on every channel.
  - Adds state HDR, entered from IDLE/FGAP instead of FETCH; HDR loads tx_data -> START. No frame-buffer read is issued for the header.
  - After the header transfer, BGAP -> FETCH with index=0.
  - Frame = BYTES_PER_FRAME+1 transfers.
- Undefined: no HDR state; the frame is exactly BYTES_PER_FRAME transfers.

Decomposition:
- Package nspi_pkg:
  - seq_state_t enum (IDLE, HDR, FETCH, LOAD, START, ACK, DONE, BGAP, FGAP);
  - HEADER_BYTE constant;
  - function gap_cnt_width(n).
- One natural sub-module, nspi_gap_timer: loadable down-counter with a done flag, shared by BGAP and FGAP.

Test Plan:
- Reset then frame_start pulse, BYTES_PER_FRAME=4, model transmitter 10-cycle busy -> exactly 4 tx_start edges, rd_addr 0,1,2,3, one frame_done, busy low afterwards.
- Frame-buffer model returns {8'h11*ch+addr} -> tx_data captured at each tx_start matches per channel and address, stable until tx_finish rises.
- frame_start held high continuously -> frames back-to-back, each separated by exactly FRAME_GAP idle cycles plus 1 frame_done cycle, with no IDLE gap.
- Two extra frame_start pulses during one frame -> exactly one additional frame is sent (pending depth 1).
- rst asserted during the ACK of byte 2 -> all outputs zero in the same cycle; a new frame_start restarts at rd_addr=0.
- With NSPI_FRAME_HEADER_EN: first transfer tx_data=8'hA5 on all channels with no rd_en; 5 transfers total for BYTES_PER_FRAME=4.
